// File: rtl/rf_pkg.sv
// Shared types and constants for the register file writeback path.
// Holds data width, register count, index type and writeback source enum.
package rf_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    WB_ALU,
    WB_MEM
  } wb_src_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: busy vector, issue WAW check, source lookups.
// Ports: issue (iss_*), commit clear (clr_*), lookups (chk_*), sticky sb_err.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iss_valid,
  input  logic                 iss_wr,
  input  logic [REG_IDX_W-1:0] iss_rd,
  output logic                 iss_ready,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] chk_rs1,
  input  logic [REG_IDX_W-1:0] chk_rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 sb_err
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            set_en;
  logic            err_q;

  assign iss_ready = !(iss_wr && busy_q[iss_rd]);
  assign set_en    = iss_valid && iss_ready
                  && iss_wr && (iss_rd != '0);

  // Bit 0 stays clear, so x0 lookups read 0.
  assign rs1_busy = busy_q[chk_rs1];
  assign rs2_busy = busy_q[chk_rs2];
  assign sb_err   = err_q;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[iss_rd]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      // Commit to a register nobody was waiting on.
      if (clr_en && !busy_q[clr_idx]) err_q <= 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Round-robin writeback arbiter (ALU vs MEM) with registered RF write port.
// Optional RF_WB_SCHED_BYPASS_EN adds rsN_fwd/rsN_fwd_data commit forwarding.
module rf_wb_sched
  import rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [XLEN-1:0]      mem_data,
  input  logic                 iss_valid,
  input  logic                 iss_wr,
  input  logic [REG_IDX_W-1:0] iss_rd,
  output logic                 iss_ready,
  input  logic [REG_IDX_W-1:0] chk_rs1,
  input  logic [REG_IDX_W-1:0] chk_rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [31:0]          rd,
  output logic [XLEN-1:0]      rd_data,
  output logic                 rd_write,
  output logic                 sb_err
`ifdef RF_WB_SCHED_BYPASS_EN
  ,
  output logic                 rs1_fwd,
  output logic [XLEN-1:0]      rs1_fwd_data,
  output logic                 rs2_fwd,
  output logic [XLEN-1:0]      rs2_fwd_data
`endif
);

  wb_src_t        last_q;
  reg_idx_t       rd_q;
  logic [XLEN-1:0] data_q;
  logic           wr_q;
  logic           grant;
  reg_idx_t       g_rd;
  logic [XLEN-1:0] g_data;
  logic           sb_rs1_busy;
  logic           sb_rs2_busy;

  // Contested cycle goes to whoever did not win last.
  assign alu_ready = alu_valid
                  && (!mem_valid || last_q == WB_MEM);
  assign mem_ready = mem_valid
                  && (!alu_valid || last_q == WB_ALU);
  assign grant     = alu_ready || mem_ready;
  assign g_rd      = alu_ready ? alu_rd : mem_rd;
  assign g_data    = alu_ready ? alu_data : mem_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= WB_MEM;
      rd_q   <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      // x0 grants are consumed but never written.
      wr_q <= grant && (g_rd != '0);
      if (grant) begin
        rd_q   <= g_rd;
        data_q <= g_data;
        last_q <= alu_ready ? WB_ALU : WB_MEM;
      end
    end
  end

  assign rd       = {{(32-REG_IDX_W){1'b0}}, rd_q};
  assign rd_data  = data_q;
  assign rd_write = wr_q;

  rf_scoreboard u_sb (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_wr    (iss_wr),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .clr_en    (wr_q),
    .clr_idx   (rd_q),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .rs1_busy  (sb_rs1_busy),
    .rs2_busy  (sb_rs2_busy),
    .sb_err    (sb_err)
  );

`ifdef RF_WB_SCHED_BYPASS_EN
  logic hit1;
  logic hit2;

  assign hit1 = wr_q && (rd_q == chk_rs1)
             && (chk_rs1 != '0);
  assign hit2 = wr_q && (rd_q == chk_rs2)
             && (chk_rs2 != '0);

  assign rs1_fwd      = hit1;
  assign rs1_fwd_data = data_q;
  assign rs2_fwd      = hit2;
  assign rs2_fwd_data = data_q;
  assign rs1_busy     = sb_rs1_busy && !hit1;
  assign rs2_busy     = sb_rs2_busy && !hit2;
`else
  assign rs1_busy = sb_rs1_busy;
  assign rs2_busy = sb_rs2_busy;
`endif

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
Writeback scheduler and scoreboard for the 32-entry register file.
- Shares the file's single write port between two requesters, ALU writeback and load/memory writeback, using valid/ready handshakes and round-robin arbitration.
- Tracks pending destination registers so decode can stall on RAW hazards (read-after-write) and WAW hazards (write-after-write).
- Sits between execute/memory stages and the register file; drives the file's rd/rd_data/rd_write inputs.

Parameters:
XLEN, 32, data width of writeback values
NREG, 32, number of architectural registers; index width is $clog2(NREG)=5

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request granted this cycle
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result, signed
mem_valid  input  1  memory writeback request
mem_ready  output  1  memory request granted this cycle
mem_rd  input  5  memory destination register
mem_data  input  XLEN  load result, signed
iss_valid  input  1  decode issues an instruction
iss_wr  input  1  issued instruction writes a register
iss_rd  input  5  issued destination register
iss_ready  output  1  issue accepted (no WAW conflict)
chk_rs1  input  5  decode source 1 index
chk_rs2  input  5  decode source 2 index
rs1_busy  output  1  source 1 has a pending write
rs2_busy  output  1  source 2 has a pending write
rd  output  32  register file write index; bits [31:5] always 0
rd_data  output  XLEN  register file write data
rd_write  output  1  register file write enable
sb_err  output  1  sticky: writeback committed to a non-busy register

Behaviour:
- Reset (reset=0, asynchronous):
  - rd=0, rd_data=0, rd_write=0.
  - All busy bits 0; sb_err=0.
  - Round-robin pointer last=MEM, so ALU wins the first contest.
- Arbitration (combinational ready):
  - Only one requester valid: it gets ready=1.
  - Both valid: the requester not equal to last gets ready=1; the other gets 0.
  - At most one of alu_ready/mem_ready is 1 per cycle.
  - last updates to the granted requester on every grant; it holds when there is no grant.
  - A requester must hold valid, rd and data stable until its ready is 1.
- Write port is output-registered:
  - On a grant at edge N, rd/rd_data/rd_write take the granted values, visible in cycle N+1; the register file writes at edge N+1.
  - Latency from grant to architectural update is 2 edges.
  - rd_write=0 in any cycle following no grant; rd/rd_data hold their last values.
- x0 handling:
  - A grant with rd index 0 is accepted (ready=1), but rd_write stays 0.
  - busy[0] is permanently 0.
- Scoreboard:
  - busy[NREG-1:1] bit vector.
  - Set: iss_valid & iss_ready & iss_wr & iss_rd!=0 sets busy[iss_rd].
  - Clear: at the edge where rd_write=1, busy[rd[4:0]] clears; this coincides with the register file write.
- Issue handshake:
  - iss_ready = !(iss_wr & busy[iss_rd]); WAW on a busy register stalls.
  - iss_wr=0 or iss_rd=0 is always ready.
- Simultaneous set and clear of the same index cannot occur, because set requires not-busy.
  - Set and clear of different indices in one cycle both take effect.
- Busy outputs: rs1_busy=busy[chk_rs1] and rs2_busy=busy[chk_rs2], combinational from current state; index 0 returns 0.
- Error case:
  - A commit with rd_write=1 to an index whose busy bit is 0 sets sb_err, which stays set until reset.
  - The write itself still proceeds.
- Reset mid-operation: pending grants and busy bits are discarded; requesters must re-present after reset.

Optional Feature:
- Macro RF_WB_SCHED_BYPASS_EN.
- Defined:
  - Adds outputs rs1_fwd (1), rs1_fwd_data (XLEN), rs2_fwd (1), rs2_fwd_data (XLEN).
  - While rd_write=1 and rd[4:0]==chk_rsN!=0: rsN_fwd=1, rsN_fwd_data=rd_data, and rsN_busy is forced 0.
  - This removes the one-cycle stall on the committing register.
- Undefined: the ports are absent and rsN_busy follows the busy bit only.

Decomposition:
- Shared package rf_pkg:
  - XLEN and NREG constants; REG_IDX_W=5.
  - Typedef reg_idx_t.
  - Enum wb_src_t {WB_ALU, WB_MEM}, used for the round-robin pointer.
- One sub-module is natural: rf_scoreboard, holding the busy vector, set/clear logic, source lookups and sb_err.
  - The arbiter and output register stay in the top level.

Test Plan:
- Reset then alu_valid=1, alu_rd=5, alu_data=0x1234:
  - alu_ready=1 same cycle.
  - Next cycle rd=5, rd_data=0x1234, rd_write=1.
  - Following cycle rd_write=0.
- ALU and memory both valid for 4 cycles (alu_rd=3, mem_rd=4), valid reasserted after each grant:
  - Grants alternate ALU, MEM, ALU, MEM.
  - Never both ready.
- Issue iss_rd=7, then chk_rs1=7:
  - rs1_busy=1 until the edge where rd_write=1 with rd=7; 0 afterwards.
  - A second issue to 7 while busy gives iss_ready=0.
- Writeback to rd=0 with mem_data=0xFFFFFFFF:
  - mem_ready=1, rd_write stays 0.
  - Issue iss_rd=0 leaves rs1_busy(chk_rs1=0)=0.
- ALU writeback to rd=9 with no prior issue: sb_err=1 after commit, remains 1 until reset is asserted.
- Assert reset with busy[7]=1 and a request pending:
  - All outputs return to reset values immediately (asynchronous).
  - busy cleared.
  - First grant after release goes to ALU.
